// File: rtl/mr_pkg.sv
// Shared definitions for the parametrised register file.
// Contents: special-register indices, the 2-bit byte-lane enable type and the lane-merge helper.
// Latency: none (types and a pure function only); no flow control.
package mr_pkg;

  // Special-register space layout: 0 = I, 1 = ACC, 2..NSP-1 = index/page registers.
  localparam int SP_I        = 0;
  localparam int SP_ACC      = 1;
  localparam int SP_IDX_BASE = 2;

  // Widest register the merge helper supports; callers zero-extend into it and truncate back.
  localparam int MAX_DW = 64;

  // [1] = high half of the word, [0] = low half.
  typedef logic [1:0] lane_t;

  localparam lane_t LANE_NONE = 2'b00;
  localparam lane_t LANE_ALL  = 2'b11;

  // Replace the halves of old_v selected by lane with the matching halves of new_v.
  // dw is the real register width; bits at and above dw come back from old_v untouched.
  function automatic logic [MAX_DW-1:0] merge(input logic [MAX_DW-1:0] old_v,
                                              input logic [MAX_DW-1:0] new_v,
                                              input lane_t             lane,
                                              input int                dw);
    logic [MAX_DW-1:0] full_m;
    logic [MAX_DW-1:0] lo_m;
    logic [MAX_DW-1:0] sel_m;
    full_m = ~({MAX_DW{1'b1}} << dw);
    lo_m   = ~({MAX_DW{1'b1}} << (dw / 2));
    sel_m  = ({MAX_DW{lane[1]}} & full_m & ~lo_m) | ({MAX_DW{lane[0]}} & lo_m);
    return (old_v & ~sel_m) | (new_v & sel_m);
  endfunction

endpackage

// File: rtl/mr_lane_reg.sv
// One DW-bit register with async reset, sync clear and a byte-lane-masked load.
// Ports: clk_i/rst_n_i clock and async active-low reset; clr_i sync clear (wins over load);
//        lane_i per-half load enable (00 = hold); d_i load data; q_o stored value.
// Latency: load visible on q_o one cycle after the edge; no backpressure.
module mr_lane_reg
  import mr_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  lane_t         lane_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  always_comb begin
    if (clr_i) begin
      q_d = '0;
    end else begin
      q_d = DW'(merge(MAX_DW'(q_q), MAX_DW'(d_i), lane_i, DW));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/mr_regfile_param.sv
// CPU register file: NGP general-purpose + NSP special registers (I, ACC, IDX2..).
// Ports: decode side src_*/dst_*/sto_i/d_in_i, ALU side sto_alu_i/acc_in_i, index post-increment
//        inc_i/inc_idx_i, debug scan dbg_en_i; outputs d_out_o (comb read), i_o, acc_o, idx_flat_o,
//        acc_conf_o (registered), debug_o/dbg_ptr_o (registered scan).
// Latency: writes visible one cycle after their edge, reads combinational with no bypass; no backpressure.
module mr_regfile_param
  import mr_pkg::*;
#(
  parameter int DW  = 16,
  parameter int NGP = 8,
  parameter int NSP = 4,
  localparam int GAW = $clog2(NGP),
  localparam int SAW = $clog2(NSP),
  localparam int AW  = (GAW > SAW) ? GAW : SAW,
  localparam int PW  = SAW + GAW + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  input  logic                  src_sp_i,
  input  logic [AW-1:0]         src_addr_i,
  input  logic                  dst_sp_i,
  input  logic [AW-1:0]         dst_addr_i,
  input  lane_t                 dst_lane_i,
  input  logic                  sto_i,
  input  logic [DW-1:0]         d_in_i,
  input  logic                  sto_alu_i,
  input  logic [DW-1:0]         acc_in_i,
  input  logic                  inc_i,
  input  logic [SAW-1:0]        inc_idx_i,
  input  logic                  dbg_en_i,
  output logic [DW-1:0]         d_out_o,
  output logic [DW-1:0]         i_o,
  output logic [DW-1:0]         acc_o,
  output logic [(NSP-2)*DW-1:0] idx_flat_o,
  output logic                  acc_conf_o,
  output logic [DW-1:0]         debug_o,
  output logic [PW-1:0]         dbg_ptr_o
);

  // Width of the index field below the space bit of the scan pointer.
  localparam int FW = SAW + GAW;

  logic [DW-1:0] gp_val [NGP];
  logic [DW-1:0] sp_val [NSP];

  // ---------------------------------------------------------------------------
  // General-purpose registers: plain decode-side writes only.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NGP; g++) begin : g_gp
    lane_t lane;
    assign lane = (sto_i && !dst_sp_i && (dst_addr_i == AW'(g))) ? dst_lane_i : LANE_NONE;

    mr_lane_reg #(.DW(DW)) u_reg (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_i),
      .lane_i  (lane),
      .d_i     (d_in_i),
      .q_o     (gp_val[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Special registers. A decode-side STO to a register always beats the ALU load
  // (ACC) or the post-increment (IDX), even when its lane mask is partial or empty.
  // ---------------------------------------------------------------------------
  for (genvar s = 0; s < NSP; s++) begin : g_sp
    logic          sto_hit;
    lane_t         lane;
    logic [DW-1:0] wdat;

    assign sto_hit = sto_i && dst_sp_i && (dst_addr_i == AW'(s));

    if (s == SP_ACC) begin : g_acc
      assign lane = sto_hit ? dst_lane_i : (sto_alu_i ? LANE_ALL : LANE_NONE);
      assign wdat = sto_hit ? d_in_i : acc_in_i;
    end else if (s >= SP_IDX_BASE) begin : g_idx
      logic inc_hit;
      assign inc_hit = inc_i && (inc_idx_i == SAW'(s));
      assign lane    = sto_hit ? dst_lane_i : (inc_hit ? LANE_ALL : LANE_NONE);
      // Natural DW-bit wrap on overflow.
      assign wdat    = sto_hit ? d_in_i : (sp_val[s] + DW'(1));
    end else begin : g_plain
      assign lane = sto_hit ? dst_lane_i : LANE_NONE;
      assign wdat = d_in_i;
    end

    mr_lane_reg #(.DW(DW)) u_reg (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (clr_i),
      .lane_i  (lane),
      .d_i     (wdat),
      .q_o     (sp_val[s])
    );
  end

  // ---------------------------------------------------------------------------
  // Read port: decoded compare so out-of-range addresses fall through to zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    d_out_o = '0;
    for (int g = 0; g < NGP; g++) begin
      if (!src_sp_i && (src_addr_i == AW'(g))) d_out_o = gp_val[g];
    end
    for (int s = 0; s < NSP; s++) begin
      if (src_sp_i && (src_addr_i == AW'(s))) d_out_o = sp_val[s];
    end
  end

  assign i_o   = sp_val[SP_I];
  assign acc_o = sp_val[SP_ACC];

  for (genvar k = SP_IDX_BASE; k < NSP; k++) begin : g_idx_out
    assign idx_flat_o[(k-SP_IDX_BASE)*DW +: DW] = sp_val[k];
  end

  // ---------------------------------------------------------------------------
  // ACC conflict flag and debug scan.
  // Scan pointer = {space, index}: GP0..GP(NGP-1), then {1, SP0..SP(NSP-1)}, then wrap.
  // ---------------------------------------------------------------------------
  logic          acc_sto_hit;
  logic          acc_conf_q, acc_conf_d;
  logic [PW-1:0] dbg_ptr_q, dbg_ptr_d;
  logic [DW-1:0] debug_q, debug_d;
  logic [DW-1:0] dbg_val;

  assign acc_sto_hit = sto_i && dst_sp_i && (dst_addr_i == AW'(SP_ACC));

  always_comb begin
    dbg_val = '0;
    for (int g = 0; g < NGP; g++) begin
      if (dbg_ptr_q == PW'(g)) dbg_val = gp_val[g];
    end
    for (int s = 0; s < NSP; s++) begin
      if (dbg_ptr_q == PW'((1 << FW) | s)) dbg_val = sp_val[s];
    end
  end

  always_comb begin
    acc_conf_d = !clr_i && acc_sto_hit && sto_alu_i;
    dbg_ptr_d  = dbg_ptr_q;
    debug_d    = debug_q;
    if (clr_i) begin
      dbg_ptr_d = '0;
      debug_d   = '0;
    end else if (dbg_en_i) begin
      debug_d = dbg_val;
      if (dbg_ptr_q == PW'(NGP - 1)) begin
        dbg_ptr_d = PW'(1 << FW);
      end else if (dbg_ptr_q == PW'((1 << FW) | (NSP - 1))) begin
        dbg_ptr_d = '0;
      end else begin
        dbg_ptr_d = dbg_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_conf_q <= 1'b0;
      dbg_ptr_q  <= '0;
      debug_q    <= '0;
    end else begin
      acc_conf_q <= acc_conf_d;
      dbg_ptr_q  <= dbg_ptr_d;
      debug_q    <= debug_d;
    end
  end

  assign acc_conf_o = acc_conf_q;
  assign dbg_ptr_o  = dbg_ptr_q;
  assign debug_o    = debug_q;

endmodule
